bist_pattern_gen: RTL and testbench

BIST stimulus side that pairs with the MISR_4bit response compactor. An LFSR generates pseudo-random test patterns for the circuit under test (CUT). The block sequences the MISR through clear, enable and signature check, then reports done/pass. It sits between the BIST start request and the CUT/MISR pair.

---
 rtl/bist_pattern_gen_pkg.sv | 41 ++++
 rtl/bist_pattern_gen_if.sv | 42 ++++
 rtl/bist_pattern_gen_lfsr_tpg.sv | 31 +++
 rtl/bist_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_bist_pattern_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pattern_gen_pkg.sv
// Shared BIST definitions: sequencer states, maximal-length LFSR taps and the default seed.
// Imported by the pattern generator and by future BIST blocks.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        FLUSH,
        DONE
    } bistState_e;

    localparam logic [3:0] DEFAULT_SEED  = 4'b0001;
    localparam int         MIN_TAP_WIDTH = 4;
    localparam int         MAX_TAP_WIDTH = 16;

    // Tap masks for a left-shifting Fibonacci LFSR whose feedback is the XOR
    // of the masked bits; bit k-1 set means polynomial term x^k.
    function automatic logic [15:0] maxLengthTaps(input int width);
        logic [15:0] taps;
        taps = 16'h000C;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h000C;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/bist_pattern_gen_if.sv
// Bus between the BIST pattern generator and its surroundings: start request,
// CUT stimulus, MISR control/signature and run status.
interface bist_pattern_gen_if #(
    parameter int WIDTH     = 4,
    parameter int SIG_WIDTH = 4
);

    logic                 start;
    logic [WIDTH-1:0]     pattern;
    logic                 patternValid;
    logic                 misrClear;
    logic                 misrEnable;
    logic [SIG_WIDTH-1:0] signature;
    logic                 busy;
    logic                 done;
    logic                 pass;

    modport master (
        input  start,
        input  signature,
        output pattern,
        output patternValid,
        output misrClear,
        output misrEnable,
        output busy,
        output done,
        output pass
    );

    modport slave (
        output start,
        output signature,
        input  pattern,
        input  patternValid,
        input  misrClear,
        input  misrEnable,
        input  busy,
        input  done,
        input  pass
    );

endinterface

// File: rtl/bist_pattern_gen_lfsr_tpg.sv
// Fibonacci LFSR test pattern generator: shifts left, feedback is the XOR of
// the tapped bits. Load has priority over advance.
module lfsr_tpg #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(4'b0001)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < 2) begin : gBadWidth
            $error("lfsr_tpg: WIDTH must be at least 2");
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (advance) begin
            q <= {q[WIDTH-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST stimulus sequencer: clears the MISR, streams NUM_PATTERNS LFSR vectors to
// the CUT, waits for the last response to land, then reports done/pass.
module bist_pattern_gen
    import bist_pkg::*;
#(
    parameter int                   WIDTH        = 4,
    parameter logic [WIDTH-1:0]     SEED         = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0]     TAPS         = WIDTH'(maxLengthTaps(WIDTH)),
    parameter int                   NUM_PATTERNS = 15,
    parameter int                   CUT_LATENCY  = 0,
    parameter int                   SIG_WIDTH    = 4,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = '0
) (
    input logic                clock,
    input logic                reset,
    bist_pattern_gen_if.master bus
);

    // One counter serves both the RUN pattern count and the FLUSH wait.
    localparam int CNT_MAX = (NUM_PATTERNS - 1 > CUT_LATENCY) ? NUM_PATTERNS - 1 : CUT_LATENCY;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    generate
        if (SEED == '0) begin : gBadSeed
            $error("bist_pattern_gen: SEED must be non-zero");
        end
        if (NUM_PATTERNS < 1) begin : gBadCount
            $error("bist_pattern_gen: NUM_PATTERNS must be at least 1");
        end
        if (CUT_LATENCY < 0) begin : gBadLatency
            $error("bist_pattern_gen: CUT_LATENCY must not be negative");
        end
    endgenerate

    bistState_e       state;
    bistState_e       stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             runLast;
    logic             flushLast;
    logic             lfsrLoad;
    logic             lfsrAdvance;
    logic [WIDTH-1:0] lfsrQ;
    logic             patternValidQ;
    logic             misrClearQ;
    logic             busyQ;
    logic             doneQ;
    logic             passQ;
    logic             misrEnableW;

    assign runLast   = (count == CNT_W'(NUM_PATTERNS - 1));
    assign flushLast = (count == CNT_W'(CUT_LATENCY));

    lfsr_tpg #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) uLfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (lfsrLoad),
        .advance (lfsrAdvance),
        .q       (lfsrQ)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Start is only looked at from IDLE and DONE, so a held start cannot restart a run.
    always_comb begin
        stateNext   = state;
        countNext   = count;
        lfsrLoad    = 1'b0;
        lfsrAdvance = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    stateNext = CLEAR;
                end
            end
            CLEAR: begin
                lfsrLoad  = 1'b1;
                countNext = '0;
                stateNext = RUN;
            end
            RUN: begin
                lfsrAdvance = 1'b1;
                if (runLast) begin
                    countNext = '0;
                    stateNext = FLUSH;
                end else begin
                    countNext = count + CNT_W'(1);
                end
            end
            FLUSH: begin
                if (flushLast) begin
                    countNext = '0;
                    stateNext = DONE;
                end else begin
                    countNext = count + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    stateNext = CLEAR;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change in step with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            patternValidQ <= 1'b0;
            misrClearQ    <= 1'b0;
            busyQ         <= 1'b0;
            doneQ         <= 1'b0;
            passQ         <= 1'b0;
        end else begin
            patternValidQ <= (stateNext == RUN);
            misrClearQ    <= (stateNext == CLEAR);
            busyQ         <= (stateNext == CLEAR) || (stateNext == RUN) || (stateNext == FLUSH);
            doneQ         <= (stateNext == DONE);
            if ((state == FLUSH) && flushLast) begin
                passQ <= (bus.signature == GOLDEN_SIG);
            end else if (stateNext != DONE) begin
                passQ <= 1'b0;
            end
        end
    end

    // The MISR enable follows pattern validity through the CUT pipeline depth.
    generate
        if (CUT_LATENCY == 0) begin : gNoDelay
            assign misrEnableW = patternValidQ;
        end else begin : gDelay
            logic [CUT_LATENCY-1:0] enDelay;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    enDelay <= '0;
                end else begin
                    enDelay <= (enDelay << 1) | CUT_LATENCY'(patternValidQ);
                end
            end
            assign misrEnableW = enDelay[CUT_LATENCY-1];
        end
    endgenerate

    assign bus.pattern      = lfsrQ;
    assign bus.patternValid = patternValidQ;
    assign bus.misrClear    = misrClearQ;
    assign bus.misrEnable   = misrEnableW;
    assign bus.busy         = busyQ;
    assign bus.done         = doneQ;
    assign bus.pass         = passQ;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Self-checking bench for bist_pattern_gen: three instances cover the default
// configuration, a CUT latency of 2 and a run longer than the LFSR period.
module tb_bist_pattern_gen;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    bist_pattern_gen_if #(.WIDTH(4), .SIG_WIDTH(4)) ifA ();
    bist_pattern_gen_if #(.WIDTH(4), .SIG_WIDTH(4)) ifB ();
    bist_pattern_gen_if #(.WIDTH(4), .SIG_WIDTH(4)) ifC ();

    bist_pattern_gen #(.GOLDEN_SIG(4'hA)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (ifA)
    );

    bist_pattern_gen #(.CUT_LATENCY(2)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (ifB)
    );

    bist_pattern_gen #(.NUM_PATTERNS(20)) dutC (
        .clock (clock),
        .reset (reset),
        .bus   (ifC)
    );

    logic       startS [3];
    logic [3:0] sigS   [3];
    logic [3:0] patW   [3];
    logic       validW [3];
    logic       enW    [3];
    logic       clearW [3];
    logic       busyW  [3];
    logic       doneW  [3];
    logic       passW  [3];

    assign ifA.start     = startS[0];
    assign ifB.start     = startS[1];
    assign ifC.start     = startS[2];
    assign ifA.signature = sigS[0];
    assign ifB.signature = sigS[1];
    assign ifC.signature = sigS[2];

    assign patW[0]   = ifA.pattern;
    assign patW[1]   = ifB.pattern;
    assign patW[2]   = ifC.pattern;
    assign validW[0] = ifA.patternValid;
    assign validW[1] = ifB.patternValid;
    assign validW[2] = ifC.patternValid;
    assign enW[0]    = ifA.misrEnable;
    assign enW[1]    = ifB.misrEnable;
    assign enW[2]    = ifC.misrEnable;
    assign clearW[0] = ifA.misrClear;
    assign clearW[1] = ifB.misrClear;
    assign clearW[2] = ifC.misrClear;
    assign busyW[0]  = ifA.busy;
    assign busyW[1]  = ifB.busy;
    assign busyW[2]  = ifC.busy;
    assign doneW[0]  = ifA.done;
    assign doneW[1]  = ifB.done;
    assign doneW[2]  = ifC.done;
    assign passW[0]  = ifA.pass;
    assign passW[1]  = ifB.pass;
    assign passW[2]  = ifC.pass;

    int assertCount = 0;
    int failCount   = 0;

    logic [3:0] seqTable [15];
    logic [3:0] expQ [$];

    typedef struct {
        logic [3:0] sig;
        logic       expPass;
        bit         holdStart;
        string      tag;
    } runVec_t;

    runVec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input int d, input string tag);
        checkOutput({tag, ".pattern"}, 32'(patW[d]), 32'h1);
        checkOutput({tag, ".patternValid"}, 32'(validW[d]), 0);
        checkOutput({tag, ".misrEnable"}, 32'(enW[d]), 0);
        checkOutput({tag, ".misrClear"}, 32'(clearW[d]), 0);
        checkOutput({tag, ".busy"}, 32'(busyW[d]), 0);
        checkOutput({tag, ".done"}, 32'(doneW[d]), 0);
        checkOutput({tag, ".pass"}, 32'(passW[d]), 0);
    endtask

    // One full run on instance d: expected patterns go to the scoreboard when
    // start is driven and are popped as the DUT presents valid vectors.
    task automatic applyStimulus(input int d, input int nPat, input int lat, input logic [3:0] sig,
                                 input logic expPass, input bit holdStart, input string tag);
        bit         vHist [0:255];
        int         clearCnt   = 0;
        int         clearCycle = -1;
        int         validCnt   = 0;
        int         firstValid = -1;
        int         lastValid  = -1;
        int         enCnt      = 0;
        int         enErr      = 0;
        int         doneCycle  = -1;
        logic [3:0] expPat;

        expQ.delete();
        for (int k = 0; k < nPat; k++) begin
            expQ.push_back(seqTable[k % 15]);
        end
        sigS[d] = sig;
        @(negedge clock);
        startS[d] = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (c == 1) begin
                checkOutput({tag, ".startDone"}, 32'(doneW[d]), 0);
                checkOutput({tag, ".startPass"}, 32'(passW[d]), 0);
                checkOutput({tag, ".startBusy"}, 32'(busyW[d]), 1);
            end
            vHist[c] = validW[d];
            if (clearW[d]) begin
                clearCnt++;
                clearCycle = c;
            end
            if (validW[d]) begin
                validCnt++;
                if (firstValid < 0) firstValid = c;
                lastValid = c;
                if (expQ.size() == 0) begin
                    checkOutput({tag, ".extraValid"}, 32'(validCnt), 32'(nPat));
                end else begin
                    expPat = expQ.pop_front();
                    checkOutput($sformatf("%s.pattern[%0d]", tag, validCnt - 1), 32'(patW[d]), 32'(expPat));
                end
            end
            if (enW[d]) enCnt++;
            if (c > lat) begin
                if (enW[d] !== vHist[c - lat]) enErr++;
            end else if (enW[d] !== 1'b0) begin
                enErr++;
            end
            if (!holdStart) startS[d] = 1'b0;
            if (doneW[d] === 1'b1) begin
                doneCycle = c;
                break;
            end
        end
        startS[d] = 1'b0;
        checkOutput({tag, ".doneReached"}, 32'(doneCycle > 0), 1);
        checkOutput({tag, ".clearPulses"}, 32'(clearCnt), 1);
        checkOutput({tag, ".clearCycle"}, 32'(clearCycle), 1);
        checkOutput({tag, ".firstValid"}, 32'(firstValid), 2);
        checkOutput({tag, ".validCount"}, 32'(validCnt), 32'(nPat));
        checkOutput({tag, ".enableCount"}, 32'(enCnt), 32'(nPat));
        checkOutput({tag, ".enableAlign"}, 32'(enErr), 0);
        checkOutput({tag, ".doneLatency"}, 32'(doneCycle - lastValid), 32'(lat + 2));
        checkOutput({tag, ".pass"}, 32'(passW[d]), 32'(expPass));
        checkOutput({tag, ".busyInDone"}, 32'(busyW[d]), 0);
        checkOutput({tag, ".scoreboardEmpty"}, 32'(expQ.size()), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;

        seqTable = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                     4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        vecs[0] = '{sig: 4'hA, expPass: 1'b1, holdStart: 1'b0, tag: "sigGolden"};
        vecs[1] = '{sig: 4'h3, expPass: 1'b0, holdStart: 1'b0, tag: "sigMiss3"};
        vecs[2] = '{sig: 4'h0, expPass: 1'b0, holdStart: 1'b0, tag: "sigMiss0"};
        vecs[3] = '{sig: 4'hB, expPass: 1'b0, holdStart: 1'b0, tag: "sigMissB"};
        vecs[4] = '{sig: 4'hA, expPass: 1'b1, holdStart: 1'b1, tag: "holdStart"};
        vecs[5] = '{sig: 4'hA, expPass: 1'b1, holdStart: 1'b0, tag: "restartDone"};

        for (int i = 0; i < 3; i++) begin
            startS[i] = 1'b0;
            sigS[i]   = 4'h0;
        end

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkIdleOutputs(0, "resetA");
        reset = 1'b0;
        @(negedge clock);
        checkIdleOutputs(0, "idleA");
        checkIdleOutputs(1, "idleB");
        checkIdleOutputs(2, "idleC");

        $display("[TB] default-configuration signature table");
        for (int v = 0; v < 6; v++) begin
            applyStimulus(0, 15, 0, vecs[v].sig, vecs[v].expPass, vecs[v].holdStart, vecs[v].tag);
            repeat (2) @(negedge clock);
            checkOutput({vecs[v].tag, ".doneHeld"}, 32'(doneW[0]), 1);
        end

        $display("[TB] reset in the middle of a run");
        @(negedge clock);
        startS[0] = 1'b1;
        @(negedge clock);
        startS[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (validW[0] === 1'b1 && patW[0] === 4'h6) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("midReset.reachedPattern6", 32'(found), 1);
        #1 reset = 1'b1;
        #1;
        checkIdleOutputs(0, "midReset");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 15, 0, 4'hA, 1'b1, 1'b0, "afterReset");

        $display("[TB] CUT latency of two");
        applyStimulus(1, 15, 2, 4'h0, 1'b1, 1'b0, "lat2Golden");
        applyStimulus(1, 15, 2, 4'h5, 1'b0, 1'b0, "lat2Miss");

        $display("[TB] twenty patterns wrap the LFSR period");
        applyStimulus(2, 20, 0, 4'h0, 1'b1, 1'b0, "wrap20");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
